control_estados: RTL and testbench
==================================

// Module: control_estados
// PURPOSE
//  Entry sequencer for the 32-bit calculator practice.
//  - Debounces the DE10-Lite push-buttons.
//  - Steps the entry index `estado` through A1..A4, B1..B4, SAL.
//  - Sits directly upstream of the operand register/display stage, which latches
//    sw[9:2] into the byte of A or B selected by `estado`.
//  - Pulses `calc_start` to the ALU when both operands are complete.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable clocks required to accept a key level (10 ms @ 50 MHz); must be >= 1
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  reset        in   1   synchronous, active-high; one clock, reset is synchronous and active-high
//  key_next_n   in   1   raw "next" button, asynchronous, active-low (pressed = 0)
//  key_clr_n    in   1   raw "clear" button, asynchronous, active-low
//  estado       out  4   entry index: 0..3 = A1..A4 (A[31:24]..A[7:0]), 4..7 = B1..B4, 8 = SAL
//  calc_start   out  1   1-clock pulse on entry to SAL
//  en_sal       out  1   level, 1 while estado == SAL
// BEHAVIOUR
//  Reset
//   - estado = 0 (A1), calc_start = 0, en_sal = 0.
//   - Synchronizer flops = 1 (released), debounced levels = released, counters = 0.
//   - Reset mid-count discards any partial debounce.
//  Per key (identical path)
//   - 2-flop synchronizer s1 -> s2.
//   - cnt increments each clock while s2 != deb; cnt clears whenever s2 == deb.
//   - When s2 != deb and cnt == DEBOUNCE_CYCLES-1: deb <= s2, cnt <= 0.
//   - press (registered) = 1 for exactly one clock after deb goes 1 -> 0.
//   - Release produces no event. A held key gives exactly one press.
//   - Bounces shorter than DEBOUNCE_CYCLES clocks are ignored.
//  Latency
//   - Raw falling edge settled before rising edge E0: press is high after edge E0+1+DEBOUNCE_CYCLES.
//   - estado updates at edge E0+2+DEBOUNCE_CYCLES.
//  FSM, on the clock where press is sampled
//   - clr press: estado <= 0 from any state; no calc_start.
//   - next press: 0->1->2->...->7->8; 8->0 (starts a new entry).
//   - clr and next in the same cycle: clr wins.
//   - No press: hold.
//   - Encodings 9..15 are unreachable; if ever decoded, next clock estado <= 0.
//  Outputs
//   - calc_start = 1 only in the clock after the 7->8 transition.
//   - en_sal = (estado == 8), registered with estado.
//   - calc_start is not re-asserted while SAL is held; it re-fires only after a new pass through B4.
//  Widths
//   - cnt is $clog2(DEBOUNCE_CYCLES+1) bits and never wraps.
//   - estado is 4 bits and never exceeds 8.
// STRUCTURE
//  Shared package calc_pkg
//   - typedef enum logic [3:0] {A1=0,A2,A3,A4,B1,B2,B3,B4,SAL=8} estado_t
//   - localparam DEBOUNCE_DEFAULT = 500000
//   - The operand stage imports the same estado_t.
//  Sub-module
//   - antirrebote (synchronizer + debounce counter + press pulse).
//   - Instantiated twice: next and clr.
//  The FSM and output registers live in control_estados.
// TESTING (bench overrides DEBOUNCE_CYCLES = 4)
//  1 Reset held 3 clocks, keys released -> estado = 0, calc_start = 0, en_sal = 0 throughout.
//  2 key_next_n low at E0, held 20 clocks -> estado 0 -> 1 at edge E0+6; single step only, no further change while held.
//  3 key_next_n glitch low for 3 clocks, then high -> estado stays 0; a 4-clock low is accepted.
//  4 Eight clean next presses -> estado walks 1..8.
//    - calc_start high for exactly one clock as estado becomes 8; en_sal = 1.
//    - A ninth press -> estado 0, en_sal = 0.
//  5 Advance to estado 5, then both keys pressed in the same clock -> estado 0, no calc_start.
//    Clear alone from 8 -> 0.
//  6 reset asserted at estado 6 mid-debounce -> estado 0 next clock.
//    The interrupted press never produces a step after reset is released.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the 32-bit calculator practice.
// Used by the entry sequencer and the operand register/display stage.
package calc_pkg;

  typedef enum logic [3:0] {
    A1  = 4'd0,
    A2  = 4'd1,
    A3  = 4'd2,
    A4  = 4'd3,
    B1  = 4'd4,
    B2  = 4'd5,
    B3  = 4'd6,
    B4  = 4'd7,
    SAL = 4'd8
  } estado_t;

  localparam int DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/control_estados_if.sv
// Button inputs and entry-sequencer outputs shared with the operand stage and ALU.
interface control_estados_if;
  import calc_pkg::*;

  logic    key_next_n;
  logic    key_clr_n;
  estado_t estado;
  logic    calc_start;
  logic    en_sal;

  modport master (
    output key_next_n,
    output key_clr_n,
    input  estado,
    input  calc_start,
    input  en_sal
  );

  modport slave (
    input  key_next_n,
    input  key_clr_n,
    output estado,
    output calc_start,
    output en_sal
  );

endinterface

// File: rtl/antirrebote.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-clock press pulse on each accepted released->pressed change.
module antirrebote
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
)
(
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             deb;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synchronized level disagrees with the
  // accepted one, so any bounce back to the old level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      deb   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb   <= s2;
        cnt   <= '0;
        press <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/control_estados.sv
// Entry sequencer: walks the operand byte index A1..A4, B1..B4, SAL on
// debounced "next" presses and fires calc_start on entering SAL.
module control_estados
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
)
(
  input  logic               clk,
  input  logic               reset,
  control_estados_if.slave   bus
);

  localparam logic [3:0] ST_A1  = 4'(A1);
  localparam logic [3:0] ST_B4  = 4'(B4);
  localparam logic [3:0] ST_SAL = 4'(SAL);

  logic       press_next;
  logic       press_clr;
  logic [3:0] estado_q;
  logic [3:0] estado_d;
  logic       calc_start_q;
  logic       en_sal_q;

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .reset (reset),
    .key_n (bus.key_next_n),
    .press (press_next)
  );

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk   (clk),
    .reset (reset),
    .key_n (bus.key_clr_n),
    .press (press_clr)
  );

  // Clear has priority over next; out-of-range codes recover to A1.
  always_comb begin
    estado_d = estado_q;
    if (estado_q > ST_SAL || press_clr) begin
      estado_d = ST_A1;
    end else if (press_next) begin
      estado_d = (estado_q == ST_SAL) ? ST_A1 : estado_q + 4'd1;
    end
  end

  // calc_start is tied to the B4->SAL step, so holding in SAL never re-fires it.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q     <= ST_A1;
      calc_start_q <= 1'b0;
      en_sal_q     <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      calc_start_q <= (estado_q == ST_B4) && (estado_d == ST_SAL);
      en_sal_q     <= (estado_d == ST_SAL);
    end
  end

  assign bus.estado     = estado_t'(estado_q);
  assign bus.calc_start = calc_start_q;
  assign bus.en_sal     = en_sal_q;

endmodule

// File: tb/tb_control_estados.sv
// Bench for control_estados: directed scenarios plus random key activity,
// all cycles compared against a sample-window reference model.
module tb_control_estados;
  import calc_pkg::*;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  control_estados_if bus();

  control_estados #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int startPulses = 0;

  // Reference model: each key is seen two clocks late; a level is accepted
  // once DEB consecutive late samples disagree with the current one.
  bit dly [2][$];
  bit win [2][$];
  bit lvl [2];
  bit pend [2];
  int expEstado;
  bit expStart;
  bit expSal;

  always @(posedge clk) begin
    bit raw [2];
    bit s;
    int prev;
    raw[0] = bus.key_next_n;
    raw[1] = bus.key_clr_n;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        dly[k].delete();
        dly[k].push_back(1'b1);
        dly[k].push_back(1'b1);
        win[k].delete();
        lvl[k]  = 1'b1;
        pend[k] = 1'b0;
      end
      expEstado = 0;
      expStart  = 1'b0;
      expSal    = 1'b0;
    end else begin
      prev = expEstado;
      if (pend[1])      expEstado = 0;
      else if (pend[0]) expEstado = (expEstado + 1) % 9;
      expStart = (prev == 7) && (expEstado == 8);
      expSal   = (expEstado == 8);
      for (int k = 0; k < 2; k++) begin
        pend[k] = 1'b0;
        s = dly[k].pop_front();
        dly[k].push_back(raw[k]);
        if (s == lvl[k]) win[k].delete();
        else             win[k].push_back(s);
        if (win[k].size() == DEB) begin
          lvl[k]  = s;
          pend[k] = (s == 1'b0);
          win[k].delete();
        end
      end
    end
  end

  task automatic checkOutput(input string tag);
    vectors++;
    assert (4'(bus.estado) === 4'(expEstado)) else begin
      miscompares++;
      $error("[TB] FAIL %s estado observed=%0d expected=%0d", tag, bus.estado, expEstado);
    end
    vectors++;
    assert (bus.calc_start === expStart) else begin
      miscompares++;
      $error("[TB] FAIL %s calc_start observed=%b expected=%b", tag, bus.calc_start, expStart);
    end
    vectors++;
    assert (bus.en_sal === expSal) else begin
      miscompares++;
      $error("[TB] FAIL %s en_sal observed=%b expected=%b", tag, bus.en_sal, expSal);
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    startPulses += int'(bus.calc_start);
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input logic nextN, input logic clrN, input int cycles, input string tag);
    bus.key_next_n = nextN;
    bus.key_clr_n  = clrN;
    for (int i = 0; i < cycles; i++) tick(tag);
  endtask

  task automatic pressNext(input string tag);
    applyStimulus(1'b0, 1'b1, 5, tag);
    applyStimulus(1'b1, 1'b1, 8, tag);
  endtask

  task automatic pressClr(input string tag);
    applyStimulus(1'b1, 1'b0, 5, tag);
    applyStimulus(1'b1, 1'b1, 8, tag);
  endtask

  initial begin
    reset          = 1'b1;
    bus.key_next_n = 1'b1;
    bus.key_clr_n  = 1'b1;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) begin
      tick("reset");
      checkValue("reset_estado", int'(bus.estado), 0);
      checkValue("reset_calc_start", int'(bus.calc_start), 0);
      checkValue("reset_en_sal", int'(bus.en_sal), 0);
    end
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 4, "idle");

    $display("[TB] glitch rejection");
    applyStimulus(1'b0, 1'b1, 3, "glitch");
    applyStimulus(1'b1, 1'b1, 10, "glitch");
    checkValue("glitch3_estado", int'(bus.estado), 0);
    applyStimulus(1'b0, 1'b1, 4, "glitch4");
    applyStimulus(1'b1, 1'b1, 10, "glitch4");
    checkValue("glitch4_estado", int'(bus.estado), 1);
    pressClr("clr");
    checkValue("clr_estado", int'(bus.estado), 0);

    $display("[TB] latency and held key");
    bus.key_next_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick("latency");
      checkValue("latency_before", int'(bus.estado), 0);
    end
    tick("latency");
    checkValue("latency_step", int'(bus.estado), 1);
    for (int i = 0; i < 13; i++) tick("held");
    checkValue("held_single_step", int'(bus.estado), 1);
    applyStimulus(1'b1, 1'b1, 10, "held_release");
    checkValue("release_no_event", int'(bus.estado), 1);
    pressClr("clr");

    $display("[TB] full walk");
    startPulses = 0;
    for (int i = 1; i <= 8; i++) begin
      pressNext("walk");
      checkValue("walk_estado", int'(bus.estado), i);
    end
    checkValue("walk_calc_start_count", startPulses, 1);
    checkValue("walk_en_sal", int'(bus.en_sal), 1);
    applyStimulus(1'b1, 1'b1, 10, "sal_hold");
    checkValue("sal_hold_no_refire", startPulses, 1);
    pressNext("wrap");
    checkValue("wrap_estado", int'(bus.estado), 0);
    checkValue("wrap_en_sal", int'(bus.en_sal), 0);

    $display("[TB] clear priority");
    for (int i = 0; i < 5; i++) pressNext("to5");
    checkValue("to5_estado", int'(bus.estado), 5);
    startPulses = 0;
    applyStimulus(1'b0, 1'b0, 5, "both");
    applyStimulus(1'b1, 1'b1, 10, "both");
    checkValue("both_estado", int'(bus.estado), 0);
    checkValue("both_calc_start_count", startPulses, 0);
    for (int i = 0; i < 8; i++) pressNext("to8");
    checkValue("to8_estado", int'(bus.estado), 8);
    pressClr("clr_from_sal");
    checkValue("clr_from_sal_estado", int'(bus.estado), 0);

    $display("[TB] reset mid-debounce");
    for (int i = 0; i < 6; i++) pressNext("to6");
    checkValue("to6_estado", int'(bus.estado), 6);
    applyStimulus(1'b0, 1'b1, 3, "partial");
    reset          = 1'b1;
    bus.key_next_n = 1'b1;
    tick("mid_reset");
    checkValue("mid_reset_estado", int'(bus.estado), 0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 15, "after_reset");
    checkValue("after_reset_estado", int'(bus.estado), 0);

    $display("[TB] random activity");
    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b1;
        tick("random_reset");
        reset = 1'b0;
      end
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1,
                    int'($urandom_range(1, 8)), "random");
    end
    applyStimulus(1'b1, 1'b1, 10, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
